sram10t_access_ctrl: RTL

Two-port access sequencer for the single-ended 10T SRAM macro. It arbitrates read/write requests from two ports, A and B, using round-robin. It then generates the timed strobe sequence the bitcell array needs: read-bitline precharge, read wordline, sense enable, write-bitline drive and write wordline. It sits between the digital request logic and the SRAM array's wordline decoder and bitline drivers.

---
 rtl/sram10t_access_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/sram10t_access_ctrl.sv
// Two-port access sequencer for a single-ended 10T SRAM macro.
// Round-robin arbitration between ports A and B, then a timed strobe sequence:
//   read : IDLE -> PRE (PRE_CYC) -> RWL (RWL_CYC) -> DONE -> IDLE
//   write: IDLE -> WDRV (1) -> WWL (WWL_CYC) -> DONE -> IDLE
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   {a,b}_valid_i/_ready_o   request handshake (ready only in IDLE, only to the granted port)
//   {a,b}_we_i/_addr_i/_wdata_i  request payload
//   {a,b}_rsp_valid_o        one-cycle completion pulse
//   {a,b}_rdata_o            last read data per port
//   arr_*                    array strobes, row address and write data; arr_rbl_data_i sensed data
//   busy_o                   high whenever not IDLE
module sram10t_access_ctrl #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned PRE_CYC = 2,
  parameter int unsigned RWL_CYC = 2,
  parameter int unsigned WWL_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic              a_rsp_valid_o,
  output logic [DATA_W-1:0] a_rdata_o,
  input  logic              b_valid_i,
  output logic              b_ready_o,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic              b_rsp_valid_o,
  output logic [DATA_W-1:0] b_rdata_o,
  output logic [ADDR_W-1:0] arr_addr_o,
  output logic              arr_pre_o,
  output logic              arr_rwl_o,
  output logic              arr_sense_o,
  output logic              arr_wbl_en_o,
  output logic [DATA_W-1:0] arr_wbl_data_o,
  output logic              arr_wwl_o,
  input  logic [DATA_W-1:0] arr_rbl_data_i,
  output logic              busy_o
);

  typedef enum logic [2:0] {StIdle, StPre, StRwl, StWdrv, StWwl, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              prio_q, prio_d;    // 0 = A has priority, 1 = B
  logic              owner_q, owner_d;  // 0 = A, 1 = B
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  logic pre_q, rwl_q, sense_q, wbl_en_q, wwl_q, a_rsp_q, b_rsp_q, busy_q;

  logic gnt_a, gnt_b;

  assign gnt_a     = a_valid_i & (~b_valid_i | ~prio_q);
  assign gnt_b     = b_valid_i & (~a_valid_i | prio_q);
  assign a_ready_o = (state_q == StIdle) & gnt_a;
  assign b_ready_o = (state_q == StIdle) & gnt_b;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prio_d    = prio_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (a_ready_o || b_ready_o) begin
          owner_d = b_ready_o;
          prio_d  = a_ready_o;  // priority passes to the port not just served
          we_d    = b_ready_o ? b_we_i    : a_we_i;
          addr_d  = b_ready_o ? b_addr_i  : a_addr_i;
          wdata_d = b_ready_o ? b_wdata_i : a_wdata_i;
          if (we_d) begin
            state_d = StWdrv;
            cnt_d   = 4'd0;
          end else begin
            state_d = StPre;
            cnt_d   = 4'(PRE_CYC - 1);
          end
        end
      end
      StPre: begin
        if (cnt_q == 4'd0) begin
          state_d = StRwl;
          cnt_d   = 4'(RWL_CYC - 1);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StRwl: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
          cnt_d   = 4'd0;
          // Sense amp is enabled this cycle; capture at its closing edge.
          if (owner_q) b_rdata_d = arr_rbl_data_i;
          else         a_rdata_d = arr_rbl_data_i;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWdrv: begin
        if (cnt_q == 4'd0) begin
          state_d = StWwl;
          cnt_d   = 4'(WWL_CYC - 1);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWwl: begin
        if (cnt_q == 4'd0) begin
          state_d = StDone;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Strobes are decoded from the next state so they come straight out of flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      prio_q    <= 1'b0;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      pre_q     <= 1'b0;
      rwl_q     <= 1'b0;
      sense_q   <= 1'b0;
      wbl_en_q  <= 1'b0;
      wwl_q     <= 1'b0;
      a_rsp_q   <= 1'b0;
      b_rsp_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prio_q    <= prio_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      pre_q     <= (state_d == StPre);
      rwl_q     <= (state_d == StRwl);
      sense_q   <= (state_d == StRwl) && (cnt_d == 4'd0);
      wbl_en_q  <= (state_d == StWdrv) || (state_d == StWwl);
      wwl_q     <= (state_d == StWwl);
      a_rsp_q   <= (state_d == StDone) && !owner_d;
      b_rsp_q   <= (state_d == StDone) && owner_d;
      busy_q    <= (state_d != StIdle);
    end
  end

  assign a_rsp_valid_o  = a_rsp_q;
  assign b_rsp_valid_o  = b_rsp_q;
  assign a_rdata_o      = a_rdata_q;
  assign b_rdata_o      = b_rdata_q;
  assign arr_addr_o     = addr_q;
  assign arr_wbl_data_o = wdata_q;
  assign arr_pre_o      = pre_q;
  assign arr_rwl_o      = rwl_q;
  assign arr_sense_o    = sense_q;
  assign arr_wbl_en_o   = wbl_en_q;
  assign arr_wwl_o      = wwl_q;
  assign busy_o         = busy_q;

endmodule
